// File: rtl/state_setting_pkg.sv
// Shared definitions for the time-entry state: edit-field encoding,
// BCD digit limits and the BCD step helper used on the mm:ss preset.
package state_setting_pkg;

  typedef enum logic {
    EDIT_MIN = 1'b0,
    EDIT_SEC = 1'b1
  } field_e;

  localparam logic [3:0] SEC_MAX_TENS = 4'd5;
  localparam logic [3:0] MIN_MAX_TENS = 4'd9;
  localparam logic [3:0] DIGIT_MAX    = 4'd9;

  // Step a two-digit BCD field by +/-1, wrapping at max_tens:DIGIT_MAX
  // (59 for seconds, 99 for minutes). The arithmetic is done per digit
  // and never in binary.
  function automatic logic [7:0] bcd_step(input logic [7:0] value,
                                          input logic       up,
                                          input logic [3:0] max_tens);
    logic [3:0] tens;
    logic [3:0] units;
    tens  = value[7:4];
    units = value[3:0];
    if (up) begin
      if (units == DIGIT_MAX) begin
        units = 4'd0;
        tens  = (tens == max_tens) ? 4'd0 : tens + 4'd1;
      end else begin
        units = units + 4'd1;
      end
    end else begin
      if (units == 4'd0) begin
        units = DIGIT_MAX;
        tens  = (tens == 4'd0) ? max_tens : tens - 4'd1;
      end else begin
        units = units - 4'd1;
      end
    end
    return {tens, units};
  endfunction

endpackage

// File: rtl/state_setting_button_autorepeat.sv
// Edge detect plus hold/auto-repeat for one debounced button. Emits a
// one-cycle step on the rising edge, again after HOLD_CYCLES of holding,
// then every REPEAT_CYCLES until release.
module button_autorepeat #(
  parameter int HOLD_CYCLES   = 500000,
  parameter int REPEAT_CYCLES = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic btn,
  input  logic clear,
  output logic step
);

  localparam int MAX_CNT = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam logic [CNT_W-1:0] HOLD_C   = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] REPEAT_C = CNT_W'(REPEAT_CYCLES);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic             btn_q;
  logic [CNT_W-1:0] cnt;
  logic             repeating;
  logic             rise;
  logic             fire;
  logic [CNT_W-1:0] limit;

  assign rise  = btn & ~btn_q;
  assign limit = repeating ? REPEAT_C : HOLD_C;
  assign fire  = btn & btn_q & (cnt == limit);
  assign step  = enable & ~clear & (rise | fire);

  // Edge register always tracks the button so a swallowed edge is never replayed later.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    if (!reset) begin
      btn_q     <= 1'b0;
      cnt       <= '0;
      repeating <= 1'b0;
    end else begin
      btn_q <= btn;
      if (!enable || clear || !btn) begin
        cnt       <= '0;
        repeating <= 1'b0;
      end else if (rise) begin
        cnt       <= ONE;
        repeating <= 1'b0;
      end else if (fire) begin
        cnt       <= ONE;
        repeating <= 1'b1;
      end else begin
        cnt <= cnt + ONE;
      end
    end
  end

endmodule

// File: rtl/state_setting.sv
// Time-entry state: edits the BCD mm:ss preset with Up/Down/Select,
// drives the preset to the countdown and a blink mask to the display.
module state_setting
  import state_setting_pkg::*;
#(
  parameter logic [2:0]  stateID       = 3'd1,
  parameter logic [15:0] DEFAULT_VALUE = 16'h0100,
  parameter int          HOLD_CYCLES   = 500000,
  parameter int          REPEAT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  currentState,
  input  logic        btnSelect,
  input  logic        btnUp,
  input  logic        btnDown,
  input  logic        blinkTick,
  output logic [15:0] initialClockValue,
  output logic [15:0] digitsOut,
  output logic [3:0]  blankMask,
  output logic        valueNonZero
);

  logic        active, active_q, entry;
  logic        sel_q, sel_edge, both, clear;
  logic        step_up, step_dn;
  field_e      field_q, field_d;
  logic [15:0] preset_q, preset_d;
  logic        blink_q, blink_d;
  logic [3:0]  mask_q, mask_d;
  logic        nz_q, nz_d;

  assign active   = (currentState == stateID);
  assign entry    = active & ~active_q;
  assign sel_edge = active & btnSelect & ~sel_q;
  assign both     = btnUp & btnDown;
  // Entry, a select edge or both buttons pressed all suppress stepping and restart hold counting.
  assign clear    = entry | sel_edge | both;

  button_autorepeat #(
    .HOLD_CYCLES   (HOLD_CYCLES),
    .REPEAT_CYCLES (REPEAT_CYCLES)
  ) u_up (
    .clk    (clk),
    .reset  (reset),
    .enable (active),
    .btn    (btnUp),
    .clear  (clear),
    .step   (step_up)
  );

  button_autorepeat #(
    .HOLD_CYCLES   (HOLD_CYCLES),
    .REPEAT_CYCLES (REPEAT_CYCLES)
  ) u_down (
    .clk    (clk),
    .reset  (reset),
    .enable (active),
    .btn    (btnDown),
    .clear  (clear),
    .step   (step_dn)
  );

  // Next-state: field FSM, preset stepping, blink phase and registered output decode.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    field_d  = field_q;
    preset_d = preset_q;
    blink_d  = blink_q;
    if (active) begin
      if (entry) begin
        field_d = EDIT_MIN;
        blink_d = 1'b0;
      end else if (sel_edge) begin
        field_d = (field_q == EDIT_MIN) ? EDIT_SEC : EDIT_MIN;
        blink_d = 1'b0;
      end else if (step_up || step_dn) begin
        blink_d = 1'b0;
        if (field_q == EDIT_MIN) begin
          preset_d[15:8] = bcd_step(preset_q[15:8], step_up, MIN_MAX_TENS);
        end else begin
          preset_d[7:0]  = bcd_step(preset_q[7:0], step_up, SEC_MAX_TENS);
        end
      end else if (blinkTick) begin
        blink_d = ~blink_q;
      end
    end
    nz_d   = (preset_d != 16'h0000);
    mask_d = 4'b0000;
    if (active && blink_d) begin
      mask_d = (field_d == EDIT_MIN) ? 4'b1100 : 4'b0011;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active_q <= 1'b0;
      sel_q    <= 1'b0;
      field_q  <= EDIT_MIN;
      preset_q <= DEFAULT_VALUE;
      blink_q  <= 1'b0;
      mask_q   <= 4'b0000;
      nz_q     <= (DEFAULT_VALUE != 16'h0000);
    end else begin
      active_q <= active;
      sel_q    <= btnSelect;
      field_q  <= field_d;
      preset_q <= preset_d;
      blink_q  <= blink_d;
      mask_q   <= mask_d;
      nz_q     <= nz_d;
    end
  end

  assign initialClockValue = preset_q;
  assign digitsOut         = preset_q;
  assign blankMask         = mask_q;
  assign valueNonZero      = nz_q;

endmodule

// File: doc/state_setting.md
Name: state_setting

Overview:
- Time-entry state of the top-level state machine.
- The user edits the BCD mm:ss preset with Up/Down/Select buttons.
- Drives initialClockValue, which the countdown state consumes on entry.
- Supplies digitsOut and a blink mask to the display path while active.

Parameters:
- stateID, 1: value of currentState for which this block is active.
- DEFAULT_VALUE, 16'h0100: reset preset (01:00). Must be legal BCD with seconds ≤ 59.
- HOLD_CYCLES, 500000: clk cycles a button must be held before auto-repeat starts.
- REPEAT_CYCLES, 100000: clk cycles between auto-repeat steps.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- currentState  in  3  global state code.
- btnSelect  in  1  debounced level, synchronous to clk.
- btnUp  in  1  debounced level, synchronous to clk.
- btnDown  in  1  debounced level, synchronous to clk.
- blinkTick  in  1  one-clk pulse, about 2 Hz.
- initialClockValue  out  16  preset {min1,min0,sec1,sec0}, BCD.
- digitsOut  out  16  digits to display; equals initialClockValue.
- blankMask  out  4  per-digit blank request; bit3 = min1 … bit0 = sec0.
- valueNonZero  out  1  high when preset ≠ 00:00.

Behaviour:
- Reset (reset=0, async):
  - preset = DEFAULT_VALUE, field = MIN, blinkPhase = 0.
  - All edge, hold and repeat registers = 0.
  - blankMask = 0; valueNonZero reflects DEFAULT_VALUE.
- Active = (currentState == stateID). Entry is detected by a registered active flag (0→1).
  - On the entry cycle: field = MIN, blinkPhase = 0, repeat counters cleared. The preset is retained.
- Inactive:
  - Buttons and blinkTick are ignored; the preset is frozen.
  - blankMask = 0; repeat counters are held at 0.
- FSM states: EDIT_MIN, EDIT_SEC.
  - A btnSelect rising edge (btn=1, registered copy=0) toggles the state.
  - The select edge also clears both repeat counters and blinkPhase.
- Steps:
  - A rising edge on Up or Down applies one step to the selected field on that clock edge; the new value is visible the next cycle.
  - While the button stays held, a per-button counter runs. When it reaches HOLD_CYCLES it steps and reloads, then steps every REPEAT_CYCLES.
  - Release clears the counter.
  - Up and Down both high: no step, both counters held at 0.
  - Select edge in the same cycle as an Up/Down edge: select wins, no step. A still-held button restarts hold counting from 0 and never generates a fresh edge step.
- Arithmetic (BCD only, never binary):
  - Seconds 00..59: 59+1 wraps to 00, 00−1 wraps to 59, no carry into minutes. A units digit 9→0 increments the tens digit.
  - Minutes 00..99: 99+1 wraps to 00, 00−1 wraps to 99.
- Blink:
  - blinkTick toggles blinkPhase while active.
  - Any step forces blinkPhase = 0, so the edited digits stay visible during adjustment.
  - blankMask = blinkPhase ? (EDIT_MIN ? 4'b1100 : 4'b0011) : 4'b0000.
- valueNonZero: registered, updated together with the preset.
- Outputs are registered; latency is one clk from the qualifying input edge.

Decomposition:
- Shared package:
  - field encoding (EDIT_MIN = 0, EDIT_SEC = 1);
  - BCD limit constants (SEC_MAX_TENS = 5, MIN_MAX_TENS = 9, DIGIT_MAX = 9).
- Sub-module button_autorepeat, instantiated twice (Up, Down):
  - inputs: clk, reset, enable, btn, clear;
  - output: one-cycle step pulse;
  - contains edge detection plus the hold/repeat counter.
- BCD increment/decrement is a function in the package.

Test Plan (HOLD_CYCLES = 8, REPEAT_CYCLES = 3):
- Reset, then currentState = 1 → initialClockValue = 16'h0100, blankMask = 0, valueNonZero = 1, field = MIN.
- Select, then a 1-cycle Up pulse at 16'h0159 → 16'h0100 (seconds wrap, minutes unchanged). Down at 16'h0000 in EDIT_SEC → 16'h0059.
- Hold Up in EDIT_MIN from 16'h0000 for 20 cycles → steps at cycles 0, 8, 11, 14, 17; preset = 16'h0500.
- Up and Down held together → no change; Select edge coincident with an Up edge → field toggles, no step.
- Pulse blinkTick in EDIT_SEC → blankMask = 4'b0011. A following Up step → 4'b0000. currentState ≠ 1 → blankMask = 0, buttons ignored, preset frozen.
- Assert reset mid-hold at 16'h4237 → 16'h0100 immediately (async); counters 0, no step after release of reset.
